// File: rtl/wide_add_seq_if.sv
// Operand/result handshake and shared 16-bit adder bus for wide_add_seq.
// slave = the sequencer side; master = the requester/adder side.
interface wide_add_seq_if #(
    parameter int NWORDS = 4
);
    // Request channel
    logic                   in_valid;
    logic                   in_ready;
    logic [16*NWORDS-1:0]   op_a;
    logic [16*NWORDS-1:0]   op_b;
    logic                   op_sub;
    logic                   op_cin;

    // Result channel
    logic                   out_valid;
    logic                   out_ready;
    logic [16*NWORDS-1:0]   res_sum;
    logic                   res_cout;
    logic                   res_ovf;

    // Shared adder
    logic                   add_req;
    logic                   add_gnt;
    logic [15:0]            add_a;
    logic [15:0]            add_b;
    logic                   add_cin;
    logic [15:0]            add_sum;
    logic                   add_cout;

    modport slave (
        input  in_valid, op_a, op_b, op_sub, op_cin,
        input  out_ready,
        input  add_gnt, add_sum, add_cout,
        output in_ready,
        output out_valid, res_sum, res_cout, res_ovf,
        output add_req, add_a, add_b, add_cin
    );

    modport master (
        output in_valid, op_a, op_b, op_sub, op_cin,
        output out_ready,
        output add_gnt, add_sum, add_cout,
        input  in_ready,
        input  out_valid, res_sum, res_cout, res_ovf,
        input  add_req, add_a, add_b, add_cin
    );
endinterface

// File: rtl/wide_add_seq.sv
// Wide add/subtract performed one 16-bit slice per granted cycle on a shared adder.
// Ports: clk, rst_n (async, active-low), bus (wide_add_seq_if.slave: request, result, adder).
module wide_add_seq #(
    parameter int NWORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wide_add_seq_if.slave bus
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NWORDS-1:0][15:0] a_q;
    logic [NWORDS-1:0][15:0] b_q;
    logic [NWORDS-1:0][15:0] sum_q;
    logic                    sub_q;
    logic                    carry_q;
    logic                    cout_q;
    logic                    ovf_q;
    logic [IW-1:0]           idx_q;

    logic                    accept;
    logic                    step;
    logic                    last;
    logic [15:0]             opa;
    logic [15:0]             opb;
    logic                    c15;

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign step   = (state_q == RUN) && bus.add_gnt;
    assign last   = (idx_q == LAST);

    // Subtract is A + ~B + carry, with carry seeded as cin ^ sub at accept.
    assign opa = a_q[idx_q];
    assign opb = sub_q ? ~b_q[idx_q] : b_q[idx_q];

    assign bus.add_a   = opa;
    assign bus.add_b   = opb;
    assign bus.add_cin = carry_q;

    // Carry into the top bit of the slice, recovered from the sum bit.
    assign c15 = opa[15] ^ opb[15] ^ bus.add_sum[15];

    assign bus.res_sum  = sum_q;
    assign bus.res_cout = cout_q;
    assign bus.res_ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_req   = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.add_req = 1'b1;
                if (bus.add_gnt && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (accept) begin
                a_q     <= bus.op_a;
                b_q     <= bus.op_b;
                sub_q   <= bus.op_sub;
                carry_q <= bus.op_cin ^ bus.op_sub;
                idx_q   <= '0;
            end
            if (step) begin
                sum_q[idx_q] <= bus.add_sum;
                carry_q      <= bus.add_cout;
                if (last) begin
                    // idx parks on the top slice until the next accept.
                    cout_q <= bus.add_cout;
                    ovf_q  <= c15 ^ bus.add_cout;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with a behavioural arithmetic model and queue scoreboard.
// Drives the request/result channels and models the shared adder with grant stalls.
module tb_wide_add_seq;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    typedef logic [W+1:0] res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wide_add_seq_if #(.NWORDS(NW)) bus ();

    wide_add_seq #(.NWORDS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign {bus.add_cout, bus.add_sum} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_cin);

    int   checks = 0;
    int   passes = 0;
    res_t exp_q[$];

    task automatic chk(input string nm, input res_t act, input res_t exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic res_t lit(input logic o, input logic c, input logic [W-1:0] s);
        return {o, c, s};
    endfunction

    // Result as {ovf, cout, sum} from plain wide arithmetic.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        logic [W:0]          u;
        logic [W-1:0]        s;
        logic                c;
        logic                o;
        logic [W+1:0]        sa;
        logic [W+1:0]        sb;
        logic [W+1:0]        t;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (!sub) begin
            u = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            s = u[W-1:0];
            c = u[W];
            t = sa + sb + (W+2)'(cin);
        end else begin
            s = a - b - W'(cin);
            c = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
            t = sa - sb - (W+2)'(cin);
        end
        o = !((t[W+1:W-1] == 3'b000) || (t[W+1:W-1] == 3'b111));
        return {o, c, s};
    endfunction

    // Scoreboard: every cycle with a result on offer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", res_t'(1), res_t'(0));
            end else begin
                chk("result", {bus.res_ovf, bus.res_cout, bus.res_sum}, exp_q[0]);
                chk("in_ready_in_done", res_t'(bus.in_ready), res_t'(0));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input res_t want,
                          input int stall_slice, input int stall_len,
                          input int hold, input logic junk);
        int lat;
        int gcnt;
        int st;
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", res_t'(bus.in_ready), res_t'(1));
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        bus.op_cin   = cin;
        @(posedge clk);
        exp_q.push_back(model(a, b, sub, cin));
        #1;
        bus.in_valid = junk;
        bus.op_a     = {$urandom, $urandom};
        bus.op_b     = {$urandom, $urandom};
        bus.op_sub   = ~sub;
        bus.op_cin   = ~cin;
        lat  = 1;
        gcnt = 0;
        st   = 0;
        while (!bus.out_valid && lat < 100) begin
            if (gcnt == stall_slice && st < stall_len) begin
                bus.add_gnt = 1'b0;
                st++;
                chk("add_req_stall", res_t'(bus.add_req), res_t'(1));
            end else begin
                bus.add_gnt = 1'b1;
                if (bus.add_req) begin
                    gcnt++;
                end
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        bus.add_gnt  = 1'b1;
        chk("latency", res_t'(lat), res_t'(NW + 1 + stall_len));
        chk("literal", {bus.res_ovf, bus.res_cout, bus.res_sum}, want);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("in_ready_backpressure", res_t'(bus.in_ready), res_t'(0));
            chk("out_valid_backpressure", res_t'(bus.out_valid), res_t'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", res_t'(bus.out_valid), res_t'(0));
        chk("in_ready_back", res_t'(bus.in_ready), res_t'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.op_cin    = 1'b0;
        bus.out_ready = 1'b0;
        bus.add_gnt   = 1'b1;
        #12;
        chk("rst_res", {bus.res_ovf, bus.res_cout, bus.res_sum}, res_t'(0));
        chk("rst_out_valid", res_t'(bus.out_valid), res_t'(0));
        chk("rst_add_req", res_t'(bus.add_req), res_t'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", res_t'(bus.in_ready), res_t'(1));

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
               lit(1'b0, 1'b0, 64'h0000_0000_0001_0000), -1, 0, 0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
               lit(1'b0, 1'b1, 64'h0), -1, 0, 0, 1'b0);
        run_op(64'h5, 64'h7, 1'b1, 1'b0,
               lit(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE), -1, 0, 0, 1'b0);
        run_op(64'h5, 64'h7, 1'b1, 1'b1,
               lit(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD), -1, 0, 0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               lit(1'b1, 1'b0, 64'h8000_0000_0000_0000), -1, 0, 0, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               lit(1'b0, 1'b0, 64'h2222_2222_2222_2211), -1, 0, 0, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               lit(1'b0, 1'b0, 64'h2222_2222_2222_2211), 1, 3, 4, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
               lit(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF), -1, 0, 1, 1'b0);
        run_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               lit(1'b0, 1'b0, 64'h2), 2, 1, 0, 1'b1);

        // Reset while the third slice is pending.
        bus.in_valid = 1'b1;
        bus.op_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.op_b     = 64'h1111_1111_1111_1111;
        bus.op_sub   = 1'b0;
        bus.op_cin   = 1'b0;
        @(posedge clk);
        exp_q.push_back(model(64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111,
                              1'b0, 1'b0));
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrun_rst_res", {bus.res_ovf, bus.res_cout, bus.res_sum}, res_t'(0));
        chk("midrun_rst_add_req", res_t'(bus.add_req), res_t'(0));
        chk("midrun_rst_out_valid", res_t'(bus.out_valid), res_t'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("no_valid_after_rst", res_t'(bus.out_valid), res_t'(0));
        end
        run_op(64'h1, 64'h1, 1'b0, 1'b0,
               lit(1'b0, 1'b0, 64'h2), -1, 0, 0, 1'b0);

        chk("queue_drained", res_t'(exp_q.size()), res_t'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter NWORDS, default 4: number of 16-bit slices per operand; legal range 2..8.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  in  1  operand request valid.
REQ-005 in_ready  out  1  block can accept an operand request.
REQ-006 op_a  in  16*NWORDS  operand A.
REQ-007 op_b  in  16*NWORDS  operand B.
REQ-008 op_sub  in  1  1 = subtract (A - B), 0 = add.
REQ-009 op_cin  in  1  carry-in (add) or borrow-in (subtract).
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 res_sum  out  16*NWORDS  result.
REQ-013 res_cout  out  1  final carry-out of the most significant slice.
REQ-014 res_ovf  out  1  two's-complement overflow flag.
REQ-015 add_req  out  1  request for the shared 16-bit adder.
REQ-016 add_gnt  in  1  adder granted this cycle.
REQ-017 add_a, add_b  out  16 each  adder operands.
REQ-018 add_cin  out  1  adder carry-in.
REQ-019 add_sum  in  16  adder sum; combinational return from add_a/add_b/add_cin.
REQ-020 add_cout  in  1  adder carry-out.

Function
REQ-021 The block SHALL be an FSM with states IDLE, RUN and DONE.
REQ-022 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; add_req SHALL be 1 only in RUN.
REQ-023 IDLE, on in_valid && in_ready:
  - capture op_a, op_b and op_sub;
  - set the carry register to op_cin XOR op_sub;
  - set slice index idx = 0;
  - go to RUN.
REQ-024 RUN, combinational outputs:
  - add_a = A[16*idx +: 16];
  - add_b = B[16*idx +: 16], bitwise inverted when sub = 1;
  - add_cin = carry register.
REQ-025 RUN with add_gnt = 1, at the clock edge:
  - res_sum[16*idx +: 16] <= add_sum;
  - carry <= add_cout;
  - idx <= idx + 1.
REQ-026 RUN with add_gnt = 0: all state, idx, carry and res_sum SHALL hold (stall); add_req stays 1.
REQ-027 The granted cycle with idx = NWORDS-1 SHALL also load res_cout <= add_cout and res_ovf, then go to DONE.
REQ-028 res_ovf SHALL equal carry-into-bit-15 XOR add_cout of the top slice; carry-into-bit-15 = add_a[15] ^ add_b[15] ^ add_sum[15], using the inverted add_b when subtracting.
REQ-029 Latency: with add_gnt held at 1, out_valid SHALL rise NWORDS+1 clock edges after the accept edge; each stalled cycle adds exactly one cycle.
REQ-030 DONE: res_sum, res_cout and res_ovf SHALL hold stable while out_valid = 1 && out_ready = 0.
REQ-031 DONE, on out_ready = 1: go to IDLE. in_ready rises the following cycle, so there is no same-cycle result/accept overlap.
REQ-032 in_valid SHALL be ignored outside IDLE; operands captured at accept SHALL NOT change if op_* toggle later.
REQ-033 Arithmetic SHALL be modulo 2^(16*NWORDS).
  - Subtract semantics: res_sum = A - B - op_cin.
  - res_cout = 1 on subtract means no borrow.
REQ-034 idx SHALL be sized ceil(log2(NWORDS)) bits minimum and SHALL never exceed NWORDS-1.

Reset
REQ-035 On rst_n = 0, asynchronously:
  - state = IDLE, idx = 0, carry = 0;
  - res_sum = 0, res_cout = 0, res_ovf = 0;
  - out_valid = 0, add_req = 0, in_ready = 1 once rst_n deasserts.
REQ-036 Reset asserted in RUN or DONE SHALL abandon the operation without emitting out_valid; the first post-reset accept SHALL behave as from power-up.

Verification
REQ-037 Add, NWORDS=4, add_gnt=1: A=0x0000_0000_0000_FFFF, B=1, cin=0 -> res_sum=0x0000_0000_0001_0000, cout=0, ovf=0; out_valid 5 edges after accept.
REQ-038 Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> res_sum=0, cout=1, ovf=0.
REQ-039 Subtract: A=5, B=7, sub=1, cin=0 -> res_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0; with cin=1 -> 0xFFFF_FFFF_FFFF_FFFD.
REQ-040 Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> res_sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-041 Arbitration stall and back-pressure:
  - add_gnt low for 3 cycles during slice 1 -> identical result, out_valid 3 cycles later;
  - out_ready low for 4 cycles in DONE -> outputs stable, in_ready stays 0.
REQ-042 Reset mid-RUN at idx=2 -> out_valid never asserts; next accept of A=1, B=1 -> res_sum=2.
